uart_fifo_bridge: RTL and testbench

Bus-side front end for the `buart` byte UART. It buffers CPU writes in a TX FIFO and drains them into `buart` one byte at a time, honouring `busy`. It also drains every received byte from `buart` into an RX FIFO for the CPU. It sits between the SoC's simple memory-mapped bus and `buart`, and provides status, sticky error flags and a level interrupt.

---
 rtl/uart_regs_pkg.sv | 21 ++
 rtl/uart_fifo_bridge_if.sv | 12 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_fifo_bridge.sv | 135 +++++++++++++
 tb/tb_uart_fifo_bridge.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_regs_pkg.sv
// Shared register map, STATUS bit positions and TX drain states for uart_fifo_bridge.
package uart_regs_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQEN  = 2'd2;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_RX_OVERRUN = 4;
  localparam int unsigned ST_TX_DROP    = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// CPU-side register bus of uart_fifo_bridge; signal names match the original port list.
interface uart_fifo_bridge_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, output we, output addr, output wdata, input rdata, input irq);
  modport slave  (input sel, input we, input addr, input wdata, output rdata, output irq);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; a push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped front end for buart: TX FIFO drained by a 3-state strobe FSM, RX FIFO filled from buart, status/irq.
module uart_fifo_bridge
  import uart_regs_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic                clk,
  input  logic                resetq,
  uart_fifo_bridge_if.slave   bus,
  output logic                uart_wr,
  output logic [7:0]          uart_tx_data,
  input  logic                uart_busy,
  output logic                uart_rd,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_valid
);
  localparam int unsigned TLW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RLW = $clog2(RX_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
  logic        rx_overrun_q, rx_overrun_d, tx_drop_q, tx_drop_d;

  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]      tx_head, rx_head;
  logic [TLW-1:0]  tx_level;
  logic [RLW-1:0]  rx_level;
  logic            rd_acc, wr_data, rd_data, wr_status, wr_irqen;
  logic [31:0]     status;

  assign rd_acc    = bus.sel & ~bus.we;
  assign wr_data   = bus.sel & bus.we & (bus.addr == ADDR_DATA);
  assign rd_data   = rd_acc & (bus.addr == ADDR_DATA);
  assign wr_status = bus.sel & bus.we & (bus.addr == ADDR_STATUS);
  assign wr_irqen  = bus.sel & bus.we & (bus.addr == ADDR_IRQEN);

  assign tx_push = wr_data;
  assign tx_pop  = (state_q == IDLE) & ~tx_empty & ~uart_busy;
  assign rx_push = uart_valid;
  assign rx_pop  = rd_data & ~rx_empty;

  // uart_rd is unconditional, so a byte arriving with a full FIFO is consumed and dropped.
  assign uart_rd      = uart_valid;
  assign uart_wr      = (state_q == ISSUE);
  assign uart_tx_data = tx_data_q;
  assign bus.rdata    = rdata_q;
  assign bus.irq      = irq_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetq(resetq), .push(tx_push), .pop(tx_pop), .wdata(bus.wdata[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetq(resetq), .push(rx_push), .pop(rx_pop), .wdata(uart_rx_data),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = rx_overrun_q;
    status[ST_TX_DROP]    = tx_drop_q;
    status[15:8]          = 8'(rx_level);
    status[23:16]         = 8'(tx_level);
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (tx_pop) begin
        state_d   = ISSUE;
        tx_data_d = tx_head;
      end
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    ie_rx_d = ie_rx_q;
    ie_tx_d = ie_tx_q;
    if (rd_acc) begin
      case (bus.addr)
        ADDR_DATA:   rdata_d = rx_empty ? '0 : {23'b0, 1'b1, rx_head};
        ADDR_STATUS: rdata_d = status;
        ADDR_IRQEN:  rdata_d = {30'b0, ie_tx_q, ie_rx_q};
        default:     rdata_d = '0;
      endcase
    end
    if (wr_irqen) begin
      ie_rx_d = bus.wdata[0];
      ie_tx_d = bus.wdata[1];
    end
    // Clear is applied before set so a same-cycle error keeps the flag.
    rx_overrun_d = (rx_overrun_q & ~(wr_status & bus.wdata[ST_RX_OVERRUN]))
                 | (uart_valid & rx_full & ~rx_pop);
    tx_drop_d    = (tx_drop_q & ~(wr_status & bus.wdata[ST_TX_DROP]))
                 | (tx_push & tx_full & ~tx_pop);
    irq_d        = (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_empty);
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      ie_rx_q      <= 1'b0;
      ie_tx_q      <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      ie_rx_q      <= ie_rx_d;
      ie_tx_q      <= ie_tx_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge with a 12-clocks-per-bit buart transmitter model and line decoder.
module tb_uart_fifo_bridge;
  import uart_regs_pkg::*;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       uart_wr, uart_busy, uart_rd;
  logic [7:0] uart_tx_data;
  logic [7:0] uart_rx_data = '0;
  logic       uart_valid = 1'b0;
  logic       busy_force = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] line_q[$];

  uart_fifo_bridge_if bus();

  uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .resetq(resetq), .bus(bus),
    .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
    .uart_rd(uart_rd), .uart_rx_data(uart_rx_data), .uart_valid(uart_valid)
  );

  always #5 clk = ~clk;

  // buart transmitter model: busy rises the cycle after wr, 10 bits of 12 clocks each.
  logic        m_busy = 1'b0;
  logic [9:0]  m_sh = 10'h3FF;
  int unsigned m_clk = 0;
  int unsigned m_bit = 0;
  logic        tx_line;
  assign uart_busy = m_busy | busy_force;
  assign tx_line   = m_busy ? m_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (uart_wr && !m_busy) begin
      m_busy <= 1'b1;
      m_sh   <= {1'b1, uart_tx_data, 1'b0};
      m_clk  <= 0;
      m_bit  <= 0;
    end else if (m_busy) begin
      if (m_clk == 11) begin
        m_clk <= 0;
        m_sh  <= {1'b1, m_sh[9:1]};
        if (m_bit == 9) m_busy <= 1'b0;
        else m_bit <= m_bit + 1;
      end else begin
        m_clk <= m_clk + 1;
      end
    end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_line);
      repeat (6) @(negedge clk);
      if (tx_line == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (12) @(negedge clk);
          b[i] = tx_line;
        end
        line_q.push_back(b);
        repeat (12) @(negedge clk);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    step();
    bus.sel = 1'b0;
    d = bus.rdata;
  endtask

  task automatic inject(input logic [7:0] b);
    uart_valid = 1'b1; uart_rx_data = b;
    step();
    uart_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetq = 1'b0; uart_valid = 1'b1;
    #1;
    checks++; if (uart_rd !== 1'b1) begin errors++; $display("FAIL reset_uart_rd: got %b expected 1", uart_rd); end
    repeat (3) step();
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL reset_uart_wr: got %b expected 0", uart_wr); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 0", uart_tx_data); end
    uart_valid = 1'b0;
    #1;
    checks++; if (uart_rd !== 1'b0) begin errors++; $display("FAIL reset_uart_rd_low: got %b expected 0", uart_rd); end
    resetq = 1'b1;
    step();
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL reset_status: got %h expected 00000006", d); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reg3_read: got %h expected 0", d); end
    bus_read(ADDR_IRQEN, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_irqen: got %h expected 0", d); end
  endtask

  task automatic test_tx();
    logic [7:0] e;
    logic [7:0] abc [3];
    logic pb, got;
    abc = '{8'h41, 8'h42, 8'h43};
    bus_write(ADDR_DATA, 32'h41); tx_exp.push_back(8'h41);
    step();
    e = tx_exp.pop_front();
    checks++; if (uart_wr !== 1'b1 || uart_tx_data !== e) begin errors++; $display("FAIL tx_latency: got wr=%b data=%h expected wr=1 data=%h", uart_wr, uart_tx_data, e); end
    bus_write(ADDR_DATA, 32'h42); tx_exp.push_back(8'h42);
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL tx_pulse_width: got %b expected 0", uart_wr); end
    bus_write(ADDR_DATA, 32'h43); tx_exp.push_back(8'h43);
    for (int k = 0; k < 2; k++) begin
      got = 1'b0; pb = 1'b1;
      for (int c = 0; c < 300 && !got; c++) begin
        pb = uart_busy;
        step();
        if (uart_wr) got = 1'b1;
      end
      e = tx_exp.pop_front();
      checks++; if (!got || uart_tx_data !== e) begin errors++; $display("FAIL tx_byte%0d: got seen=%b data=%h expected seen=1 data=%h", k + 1, got, uart_tx_data, e); end
      checks++; if (pb !== 1'b0) begin errors++; $display("FAIL tx_busy_gate%0d: got busy=%b before wr expected 0", k + 1, pb); end
      step();
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL tx_pulse_width%0d: got %b expected 0", k + 1, uart_wr); end
    end
    for (int c = 0; c < 500 && line_q.size() < 3; c++) step();
    checks++; if (line_q.size() !== 3) begin errors++; $display("FAIL tx_line_count: got %0d expected 3", line_q.size()); end
    for (int i = 0; i < 3 && line_q.size() > 0; i++) begin
      e = line_q.pop_front();
      checks++; if (e !== abc[i]) begin errors++; $display("FAIL tx_line_char%0d: got %h expected %h", i, e, abc[i]); end
    end
  endtask

  task automatic test_tx_drop();
    logic [31:0] d;
    logic [7:0]  e;
    logic        got;
    for (int c = 0; c < 300 && m_busy; c++) step();
    busy_force = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      bus_write(ADDR_DATA, 32'h60 + i);
      if (i < 16) tx_exp.push_back(8'(8'h60 + i));
    end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0010_0025) begin errors++; $display("FAIL tx_drop_status: got %h expected 00100025", d); end
    bus_write(ADDR_STATUS, 32'h20);
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0010_0005) begin errors++; $display("FAIL tx_drop_clear: got %h expected 00100005", d); end
    busy_force = 1'b0;
    for (int k = 0; k < 16; k++) begin
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        step();
        if (uart_wr) got = 1'b1;
      end
      e = tx_exp.pop_front();
      checks++; if (!got || uart_tx_data !== e) begin errors++; $display("FAIL tx_drain%0d: got seen=%b data=%h expected seen=1 data=%h", k, got, uart_tx_data, e); end
    end
    for (int c = 0; c < 300 && m_busy; c++) step();
    repeat (20) step();
    line_q.delete();
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL tx_drain_status: got %h expected 00000006", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < 17; i++) begin
      inject(8'(i));
      if (i < 16) rx_exp.push_back(8'(i));
    end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_101A) begin errors++; $display("FAIL rx_overrun_status: got %h expected 0000101A", d); end
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = ADDR_STATUS; bus.wdata = 32'h10;
    uart_valid = 1'b1; uart_rx_data = 8'hEE;
    step();
    bus.sel = 1'b0; bus.we = 1'b0; uart_valid = 1'b0;
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_101A) begin errors++; $display("FAIL rx_set_wins: got %h expected 0000101A", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA, d);
      e = rx_exp.pop_front();
      checks++; if (d !== {23'b0, 1'b1, e}) begin errors++; $display("FAIL rx_read%0d: got %h expected %h", i, d, {23'b0, 1'b1, e}); end
    end
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_read_empty: got %h expected 0", d); end
    bus_write(ADDR_STATUS, 32'h10);
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL rx_overrun_clear: got %h expected 00000006", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(ADDR_IRQEN, 32'h1);
    step();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", bus.irq); end
    inject(8'h5A); rx_exp.push_back(8'h5A);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_push_edge: got %b expected 0", bus.irq); end
    step();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", bus.irq); end
    bus_read(ADDR_DATA, d);
    e = rx_exp.pop_front();
    checks++; if (d !== {23'b0, 1'b1, e}) begin errors++; $display("FAIL irq_read: got %h expected %h", d, {23'b0, 1'b1, e}); end
    step();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", bus.irq); end
    bus_write(ADDR_IRQEN, 32'h2);
    step();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b expected 1", bus.irq); end
    bus_read(ADDR_IRQEN, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL irqen_read: got %h expected 2", d); end
    bus_write(ADDR_IRQEN, 32'h0);
    step();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b expected 0", bus.irq); end
  endtask

  task automatic test_rx_collide();
    logic [31:0] d;
    logic [7:0]  e;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = ADDR_DATA;
    uart_valid = 1'b1; uart_rx_data = 8'h33;
    step();
    bus.sel = 1'b0; uart_valid = 1'b0;
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL collide_empty_read: got %h expected 0", bus.rdata); end
    rx_exp.push_back(8'h33);
    bus_read(ADDR_DATA, d);
    e = rx_exp.pop_front();
    checks++; if (d !== {23'b0, 1'b1, e}) begin errors++; $display("FAIL collide_empty_kept: got %h expected %h", d, {23'b0, 1'b1, e}); end
    for (int i = 0; i < 16; i++) begin
      inject(8'(8'h80 + i));
      rx_exp.push_back(8'(8'h80 + i));
    end
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = ADDR_DATA;
    uart_valid = 1'b1; uart_rx_data = 8'h77;
    step();
    bus.sel = 1'b0; uart_valid = 1'b0;
    e = rx_exp.pop_front();
    rx_exp.push_back(8'h77);
    checks++; if (bus.rdata !== {23'b0, 1'b1, e}) begin errors++; $display("FAIL collide_full_read: got %h expected %h", bus.rdata, {23'b0, 1'b1, e}); end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_100A) begin errors++; $display("FAIL collide_full_status: got %h expected 0000100A", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA, d);
      e = rx_exp.pop_front();
      checks++; if (d !== {23'b0, 1'b1, e}) begin errors++; $display("FAIL collide_drain%0d: got %h expected %h", i, d, {23'b0, 1'b1, e}); end
    end
    bus_read(ADDR_STATUS, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL collide_end_status: got %h expected 00000006", d); end
  endtask

  initial begin
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_tx();
    test_tx_drop();
    test_rx_overrun();
    test_irq();
    test_rx_collide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
